// File: rtl/adder_pkg.sv
// Shared types and opcode decode helpers for the pipelined adder.
`ifndef XLEN
`define XLEN 32
`endif

package adder_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_ADC  = 3'd2,
        OP_SBC  = 3'd3,
        OP_SLT  = 3'd4,
        OP_SLTU = 3'd5
    } adder_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } adder_flags_t;

    // Subtract-like ops feed the inverted B operand into the chain.
    function automatic logic op_binv(input logic [2:0] op);
        case (op)
            OP_SUB, OP_SBC, OP_SLT, OP_SLTU: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // Reserved opcodes fall through to the ADD carry-in of zero.
    function automatic logic op_cin(input logic [2:0] op, input logic cin);
        case (op)
            OP_ADC, OP_SBC:          return cin;
            OP_SUB, OP_SLT, OP_SLTU: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit carry slice; one instance per pipeline stage.
module adder_slice
    import adder_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co,
    output logic         zero,
    output logic         msb
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign zero      = (sum == {W{1'b0}});
    assign msb       = sum[W-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined XLEN-bit add/sub/compare: one carry slice per stage, valid/ready
// handshake with whole-pipe stall, synchronous flush and n/z/c/v flags.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int XLEN   = `XLEN,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            cin,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            n,
    output logic            z,
    output logic            c,
    output logic            v
);

    localparam int W = XLEN / STAGES;

    logic            adv_s;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    adder_flags_t    flags_r;

    assign adv_s     = !out_valid_r || out_ready;
    assign in_ready  = adv_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign n         = flags_r.n;
    assign z         = flags_r.z;
    assign c         = flags_r.c;
    assign v         = flags_r.v;

    // as_* holds finished sum bits below slice k and untouched A bits above;
    // bx_* holds only the (possibly inverted) B bits not yet consumed.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int BXW = XLEN - k * W;

        logic            v_in_s;
        logic [2:0]      op_in_s;
        logic [XLEN-1:0] as_in_s;
        logic [BXW-1:0]  bx_in_s;
        logic            c_in_s;
        logic            z_in_s;
        logic [W-1:0]    slice_sum_s;
        logic            slice_co_s;
        logic            slice_zero_s;
        logic [XLEN-1:0] as_out_s;

        if (k == 0) begin : g_first
            assign v_in_s  = in_valid;
            assign op_in_s = op;
            assign as_in_s = a;
            assign bx_in_s = op_binv(op) ? ~b : b;
            assign c_in_s  = op_cin(op, cin);
            assign z_in_s  = 1'b1;
        end else begin : g_next
            assign v_in_s  = g_stage[k-1].g_reg.v_r;
            assign op_in_s = g_stage[k-1].g_reg.op_r;
            assign as_in_s = g_stage[k-1].g_reg.as_r;
            assign bx_in_s = g_stage[k-1].g_reg.bx_r;
            assign c_in_s  = g_stage[k-1].g_reg.c_r;
            assign z_in_s  = g_stage[k-1].g_reg.z_r;
        end

        // Splice this slice's sum over the A bits it just consumed.
        always_comb begin
            as_out_s              = as_in_s;
            as_out_s[k*W +: W]    = slice_sum_s;
        end

        if (k < STAGES - 1) begin : g_reg
            logic                  v_r;
            logic [2:0]            op_r;
            logic [XLEN-1:0]       as_r;
            logic [BXW-W-1:0]      bx_r;
            logic                  c_r;
            logic                  z_r;
            logic                  unused_msb_s;

            adder_slice #(.W(W)) u_slice (
                .a    (as_in_s[k*W +: W]),
                .b    (bx_in_s[W-1:0]),
                .ci   (c_in_s),
                .sum  (slice_sum_s),
                .co   (slice_co_s),
                .zero (slice_zero_s),
                .msb  (unused_msb_s)
            );

            // Intermediate stage register; flush kills validity, stall holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_r  <= 1'b0;
                    op_r <= 3'd0;
                    as_r <= {XLEN{1'b0}};
                    bx_r <= {(BXW-W){1'b0}};
                    c_r  <= 1'b0;
                    z_r  <= 1'b0;
                end else if (flush) begin
                    v_r  <= 1'b0;
                end else if (adv_s) begin
                    v_r  <= v_in_s;
                    op_r <= op_in_s;
                    as_r <= as_out_s;
                    bx_r <= bx_in_s[BXW-1:W];
                    c_r  <= slice_co_s;
                    z_r  <= z_in_s & slice_zero_s;
                end
            end
        end else begin : g_last
            logic         msb_s;
            adder_flags_t flags_s;
            logic [XLEN-1:0] res_s;

            adder_slice #(.W(W)) u_slice (
                .a    (as_in_s[k*W +: W]),
                .b    (bx_in_s[W-1:0]),
                .ci   (c_in_s),
                .sum  (slice_sum_s),
                .co   (slice_co_s),
                .zero (slice_zero_s),
                .msb  (msb_s)
            );

            // bx msb already carries binv, so equal signs here mean the
            // effective addends agree and a sign change is an overflow.
            always_comb begin
                flags_s.n = msb_s;
                flags_s.z = z_in_s & slice_zero_s;
                flags_s.c = slice_co_s;
                flags_s.v = (as_in_s[XLEN-1] ^ msb_s) & ~(as_in_s[XLEN-1] ^ bx_in_s[W-1]);
                case (op_in_s)
                    OP_SLT:  res_s = {{(XLEN-1){1'b0}}, flags_s.n ^ flags_s.v};
                    OP_SLTU: res_s = {{(XLEN-1){1'b0}}, ~flags_s.c};
                    default: res_s = as_out_s;
                endcase
            end

            // Output register doubles as the final pipeline stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_r <= 1'b0;
                    result_r    <= {XLEN{1'b0}};
                    flags_r     <= '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};
                end else if (flush) begin
                    out_valid_r <= 1'b0;
                end else if (adv_s) begin
                    out_valid_r <= v_in_s;
                    result_r    <= res_s;
                    flags_r     <= flags_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: directed plan cases, back-to-back,
// backpressure, random ready, flush and asynchronous reset.
module tb_adder_pipe;
    import adder_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            cin;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            n, z, c, v;

    adder_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: 33-bit unsigned sum for c, sign-extended sum for v,
    // and native comparisons for SLT/SLTU.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic ci);
        logic [31:0] bx;
        logic        c0;
        logic [32:0] uf;
        logic [32:0] sf;
        exp_t        e;
        case (o)
            3'd1, 3'd4, 3'd5: begin bx = ~y; c0 = 1'b1; end
            3'd2:             begin bx = y;  c0 = ci;   end
            3'd3:             begin bx = ~y; c0 = ci;   end
            default:          begin bx = y;  c0 = 1'b0; end
        endcase
        uf = {1'b0, x} + {1'b0, bx} + {32'd0, c0};
        sf = {x[31], x} + {bx[31], bx} + {32'd0, c0};
        e.flg = {uf[31], (uf[31:0] == 32'd0), uf[32], sf[32] ^ sf[31]};
        case (o)
            3'd4:    e.res = {31'd0, ($signed(x) < $signed(y))};
            3'd5:    e.res = {31'd0, (x < y)};
            default: e.res = uf[31:0];
        endcase
        return e;
    endfunction

    // Monitor: handshakes are sampled mid-cycle, where inputs are stable.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_extra", {63'd0, out_valid}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("sb_res", {32'd0, result}, {32'd0, e.res});
                    check_eq("sb_flags", {60'd0, n, z, c, v}, {60'd0, e.flg});
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(model(op, a, b, cin));
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic ci);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        cin      = ci;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        check_eq("accept", {63'd0, ok}, 64'd1);
    endtask

    // Single op into an empty pipe with out_ready high; checks latency
    // and the literal result/flags before the monitor consumes it.
    task automatic single(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic ci,
                          input logic [31:0] exp_res, input logic [3:0] exp_flg);
        send(o, x, y, ci);
        in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            check_eq("lat_wait", {63'd0, out_valid}, 64'd0);
            @(posedge clk);
            #1;
        end
        check_eq("lat_valid", {63'd0, out_valid}, 64'd1);
        check_eq("lit_res", {32'd0, result}, {32'd0, exp_res});
        check_eq("lit_flags", {60'd0, n, z, c, v}, {60'd0, exp_flg});
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check_eq("drain", 64'(sb_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c_start;
        logic [31:0] held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        a         = 32'd0;
        b         = 32'd0;
        cin       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        held      = 32'd0;

        #12;
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_res", {32'd0, result}, 64'd0);
        check_eq("rst_flags", {60'd0, n, z, c, v}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_ready", {63'd0, in_ready}, 64'd1);

        // Plan cases; flags are {n,z,c,v}.
        single(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110);
        single(3'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0011);
        single(3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 4'b1010);
        single(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010);
        single(3'd2, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0003, 4'b0000);
        single(3'd3, 32'h0000_0005, 32'h0000_0002, 1'b0, 32'h0000_0002, 4'b0010);
        drain();

        // Back-to-back issue must take exactly one cycle per op.
        c_start = cyc;
        send(3'd2, 32'h0000_0001, 32'h0000_0001, 1'b1);
        send(3'd3, 32'h0000_0005, 32'h0000_0002, 1'b0);
        send(3'd6, 32'h0000_FFFF, 32'h0000_0001, 1'b1);
        send(3'd7, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        in_valid = 1'b0;
        check_eq("tput", 64'(cyc - c_start), 64'd4);
        drain();

        // Backpressure: in_ready drops once the output register is full.
        out_ready = 1'b0;
        fork
            begin
                send(3'd0, 32'h0000_0010, 32'h0000_0020, 1'b0);
                send(3'd1, 32'h0000_0010, 32'h0000_0020, 1'b0);
                send(3'd4, 32'h8000_0000, 32'h0000_0001, 1'b0);
                send(3'd5, 32'h8000_0000, 32'h0000_0001, 1'b0);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    check_eq("bp_ready", {63'd0, in_ready}, (i < 2) ? 64'd1 : 64'd0);
                    if (i >= 2) begin
                        check_eq("bp_valid", {63'd0, out_valid}, 64'd1);
                        if (i == 2) held = result;
                        else check_eq("bp_hold", {32'd0, result}, {32'd0, held});
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random ops with random consumer backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (100) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush with two ops in flight (output stalled) plus one offered.
        out_ready = 1'b0;
        send(3'd0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        send(3'd0, 32'h0000_0003, 32'h0000_0004, 1'b0);
        in_valid = 1'b1;
        a        = 32'h0000_0005;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < STAGES + 1; i++) begin
            check_eq("flush_a", {63'd0, out_valid}, 64'd0);
            @(posedge clk);
            #1;
        end

        // Flush in the same cycle as an accept discards that op.
        in_valid = 1'b1;
        op       = 3'd0;
        a        = 32'h0000_0009;
        b        = 32'h0000_0009;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < STAGES + 1; i++) begin
            check_eq("flush_b", {63'd0, out_valid}, 64'd0);
            @(posedge clk);
            #1;
        end
        single(3'd0, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 4'b0000);
        drain();

        // Asynchronous reset during a stalled output.
        out_ready = 1'b0;
        send(3'd1, 32'h0000_0000, 32'h0000_0001, 1'b0);
        in_valid = 1'b0;
        repeat (STAGES - 1) @(posedge clk);
        @(posedge clk);
        #2;
        check_eq("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        check_eq("pre_rst_res", {32'd0, result}, {32'd0, 32'hFFFF_FFFF});
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("arst_res", {32'd0, result}, 64'd0);
        check_eq("arst_flags", {60'd0, n, z, c, v}, 64'd0);
        sb_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        single(3'd0, 32'h0000_0007, 32'h0000_0008, 1'b0, 32'h0000_000F, 4'b0000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle integer adder; XLEN-bit add/subtract split into STAGES carry-chained slices, one slice per pipeline stage.
- Adds carry-in modes (ADC/SBC), signed/unsigned compare (SLT/SLTU), valid/ready handshakes and flush.
- Sits in the execute stage as the arithmetic unit for wide or high-frequency configurations; delivers n/z/c/v flags alongside each result.

Parameters:
- XLEN, `XLEN (32), operand/result width.
- STAGES, 2, pipeline depth and slice count; XLEN % STAGES == 0, 1 <= STAGES <= XLEN; slice width W = XLEN/STAGES.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts this cycle.
- op  in  3  adder_op_e: ADD=0, SUB=1, ADC=2, SBC=3, SLT=4, SLTU=5; 6,7 reserved.
- a, b  in  XLEN  operands.
- cin  in  1  carry-in, used only by ADC/SBC.
- flush  in  1  synchronous kill of all in-flight ops.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  sum/difference, or compare bit.
- n, z, c, v  out  1 each  flags of the arithmetic sum.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0; out_valid=0; result=0; n=z=c=v=0. Datapath registers may also be cleared; they are never observable while invalid.
- Advance: adv = !out_valid || out_ready. The whole pipe shifts on adv. in_ready = adv, combinational, with no dependence on in_valid.
- Accept: occurs when in_valid && in_ready at a rising edge.
- Latency: an op accepted at edge t shows out_valid=1 after edge t+STAGES-1, i.e. STAGES register stages including the output register. Throughput is 1 op/cycle when out_ready is held high.
- Carry-in and operand inversion per op:
  - ADD: binv=0, c0=0.
  - SUB, SLT, SLTU: binv=1, c0=1.
  - ADC: binv=0, c0=cin.
  - SBC: binv=1, c0=cin.
  - Reserved opcodes behave as ADD.
- Slicing: stage k (0-based) computes bits [k*W +: W] of a + (binv ? ~b : b) + carry_k. carry_0 = c0; carry_{k+1} comes from stage k's registered carry-out. Not-yet-used operand slices and already-computed result slices travel with the op in stage registers.
- Flags, computed at the final slice:
  - n = sum[XLEN-1].
  - z = (sum == 0), accumulated as an AND of per-slice zero bits.
  - c = carry out of bit XLEN-1. After SUB, c=1 means no borrow.
  - v = (a[XLEN-1] ^ sum[XLEN-1]) & ~(binv ^ a[XLEN-1] ^ b[XLEN-1]).
- Compare ops:
  - SLT: result = {0, n^v}.
  - SLTU: result = {0, ~c}.
  - Flags still reflect the subtraction.
- Stall: with out_valid && !out_ready, every stage register, result and all flags hold stable; in_ready=0.
- Flush: at the edge where flush=1, all stage valid bits and out_valid are cleared. Any accept in that cycle is discarded. Flush has priority over accept and over stall. Data outputs may keep stale values but out_valid=0.
- Wrap-around: modular XLEN-bit arithmetic, with overflow reported only through c/v.
- STAGES=1: collapses to a single registered adder with latency 1.
- Reset mid-operation: reset immediately invalidates everything, including a pending stalled output.

Decomposition:
- Package adder_pkg:
  - adder_op_e enum (3 bits).
  - adder_flags_t struct {n,z,c,v}.
  - Function op_binv(op) and function op_cin(op, cin).
- Sub-module adder_slice #(W): combinational W-bit a+b+ci producing sum, co, zero and msb outputs. Instantiated STAGES times in a generate loop; the stage registers live in adder_pipe.

Test Plan:
- XLEN=32, STAGES=2, out_ready=1:
  - ADD 0xFFFF_FFFF + 0x1 → after 2 cycles result=0, z=1, c=1, v=0, n=0. Confirms carry crossing the slice boundary at bit 16.
  - SUB 0x8000_0000 − 0x1 → result=0x7FFF_FFFF, v=1, c=1, n=0.
  - SLT a=0xFFFF_FFFF (−1), b=0x1 → result=1. SLTU with the same operands → result=0.
- Back-to-back ops with carry-in: ADC 0x1+0x1, cin=1 → result=3; SBC 0x5−0x2, cin=0 → result=2, c=1. Issue one per cycle and check ordering and throughput of 1.
- Backpressure: out_ready=0 for 5 cycles with in_valid held high. Check in_ready=0 from the cycle after the pipe fills, outputs stable throughout, and no ops lost or duplicated after release.
- Flush and reset:
  - Flush with 2 ops in flight plus 1 offered → out_valid stays 0 afterwards; the next accepted op emerges normally.
  - Assert rst_n=0 mid-stall → out_valid=0, result=0 and all flags=0 immediately, without waiting for a clock edge.
